// File: rtl/mips_defs.sv
// Shared MIPS control encodings: opcodes, functs, FSM states and datapath mux codes.
// The datapath mux decoders use the same constants so both sides agree on every select value.
package mips_defs;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  localparam logic [1:0] NPC_PC4  = 2'b00;
  localparam logic [1:0] NPC_BEQ  = 2'b01;
  localparam logic [1:0] NPC_JUMP = 2'b10;
  localparam logic [1:0] NPC_JR   = 2'b11;

  localparam logic [1:0] EXT_SIGN = 2'b00;
  localparam logic [1:0] EXT_ZERO = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_DM  = 2'b01;
  localparam logic [1:0] WD_PC4 = 2'b10;

  typedef struct packed {
    logic addu;
    logic subu;
    logic ori;
    logic lw;
    logic sw;
    logic beq;
    logic lui;
    logic j;
    logic jal;
    logic jr;
    logic unknown;
  } iclass_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle controller (master) and the shared datapath (slave).
interface mc_ctrl_if;
  logic [31:0] instr;
  logic        zero;
  logic        pc_wr;
  logic [1:0]  npc_op;
  logic        ir_wr;
  logic        reg_wr;
  logic [1:0]  reg_dst;
  logic [1:0]  wd_sel;
  logic [1:0]  ext_op;
  logic        alu_src;
  logic [1:0]  alu_op;
  logic        mem_wr;

  modport master (
    input  instr, zero,
    output pc_wr, npc_op, ir_wr, reg_wr, reg_dst, wd_sel,
           ext_op, alu_src, alu_op, mem_wr
  );

  modport slave (
    output instr, zero,
    input  pc_wr, npc_op, ir_wr, reg_wr, reg_dst, wd_sel,
           ext_op, alu_src, alu_op, mem_wr
  );
endinterface

// File: rtl/mc_decode.sv
// Combinational instruction classifier: maps the IR word to a one-hot instruction class.
module mc_decode
  import mips_defs::*;
(
  input  logic [31:0] instr,
  output iclass_t     cls
);

  logic [5:0] op;
  logic [5:0] funct;
  logic       unused_fields;

  assign op    = instr[31:26];
  assign funct = instr[5:0];
  // Register/immediate fields only matter to the datapath.
  assign unused_fields = ^instr[25:6];

  always_comb begin
    cls      = '0;
    cls.addu = (op == OP_RTYPE) && (funct == FN_ADDU);
    cls.subu = (op == OP_RTYPE) && (funct == FN_SUBU);
    cls.jr   = (op == OP_RTYPE) && (funct == FN_JR);
    cls.ori  = (op == OP_ORI);
    cls.lw   = (op == OP_LW);
    cls.sw   = (op == OP_SW);
    cls.beq  = (op == OP_BEQ);
    cls.lui  = (op == OP_LUI);
    cls.j    = (op == OP_J);
    cls.jal  = (op == OP_JAL);
    cls.unknown = ~(cls.addu | cls.subu | cls.jr | cls.ori | cls.lw |
                    cls.sw | cls.beq | cls.lui | cls.j | cls.jal);
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS controller: FETCH/DECODE/EXE/MEM/WB sequencing with combinational
// enables and selects, plus a free-running cycle counter.
module mc_ctrl
  import mips_defs::*;
#(
  parameter logic [31:0] IM_BASE = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  mc_ctrl_if.master   bus,
  output logic [31:0] pc_rst_val,
  output logic [2:0]  state,
  output logic        instr_done,
  output logic [31:0] cycle_cnt
);

  state_t  cur_state;
  state_t  nxt_state;
  iclass_t cls;

  mc_decode u_decode (
    .instr (bus.instr),
    .cls   (cls)
  );

  assign pc_rst_val = IM_BASE;
  assign state      = cur_state;

  always_ff @(posedge clk) begin
    if (reset) cur_state <= S_FETCH;
    else       cur_state <= nxt_state;
  end

  always_ff @(posedge clk) begin
    if (reset) cycle_cnt <= '0;
    else       cycle_cnt <= cycle_cnt + 32'd1;
  end

  always_comb begin
    nxt_state = S_FETCH;
    case (cur_state)
      S_FETCH:  nxt_state = S_DECODE;
      S_DECODE: begin
        if (cls.j || cls.jr || cls.unknown) nxt_state = S_FETCH;
        else if (cls.jal)                   nxt_state = S_WB;
        else                                nxt_state = S_EXE;
      end
      S_EXE: begin
        if (cls.beq)              nxt_state = S_FETCH;
        else if (cls.lw || cls.sw) nxt_state = S_MEM;
        else                       nxt_state = S_WB;
      end
      S_MEM:   nxt_state = cls.lw ? S_WB : S_FETCH;
      S_WB:    nxt_state = S_FETCH;
      default: nxt_state = S_FETCH;
    endcase
  end

  // Everything is gated by reset so an abandoned instruction never writes state.
  always_comb begin
    bus.pc_wr   = 1'b0;
    bus.npc_op  = NPC_PC4;
    bus.ir_wr   = 1'b0;
    bus.reg_wr  = 1'b0;
    bus.reg_dst = DST_RT;
    bus.wd_sel  = WD_ALU;
    bus.ext_op  = EXT_SIGN;
    bus.alu_src = 1'b0;
    bus.alu_op  = ALU_ADD;
    bus.mem_wr  = 1'b0;
    instr_done  = 1'b0;
    if (!reset) begin
      // ALU selects stay at their EXE values through MEM/WB since the datapath does not hold them.
      if (cur_state == S_EXE || cur_state == S_MEM || cur_state == S_WB) begin
        if (cls.subu || cls.beq) bus.alu_op = ALU_SUB;
        if (cls.ori || cls.lui)  bus.alu_op = ALU_OR;
        if (cls.ori || cls.lui || cls.lw || cls.sw) bus.alu_src = 1'b1;
        if (cls.ori) bus.ext_op = EXT_ZERO;
        if (cls.lui) bus.ext_op = EXT_LUI;
      end
      case (cur_state)
        S_FETCH: begin
          bus.ir_wr = 1'b1;
          bus.pc_wr = 1'b1;
        end
        S_DECODE: begin
          if (cls.j || cls.jal) begin
            bus.pc_wr  = 1'b1;
            bus.npc_op = NPC_JUMP;
          end
          if (cls.jr) begin
            bus.pc_wr  = 1'b1;
            bus.npc_op = NPC_JR;
          end
          instr_done = cls.j | cls.jr | cls.unknown;
        end
        S_EXE: begin
          if (cls.beq) begin
            instr_done = 1'b1;
            if (bus.zero) begin
              bus.pc_wr  = 1'b1;
              bus.npc_op = NPC_BEQ;
            end
          end
        end
        S_MEM: begin
          if (cls.sw) begin
            bus.mem_wr = 1'b1;
            instr_done = 1'b1;
          end
        end
        S_WB: begin
          bus.reg_wr = 1'b1;
          instr_done = 1'b1;
          if (cls.addu || cls.subu) bus.reg_dst = DST_RD;
          if (cls.jal) begin
            bus.reg_dst = DST_RA;
            bus.wd_sel  = WD_PC4;
          end
          if (cls.lw) bus.wd_sel = WD_DM;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed scoreboard bench for mc_ctrl: each stimulus cycle queues its hand-computed
// control vector and cycle count; a negedge monitor pops and compares.
module tb_mc_ctrl;
  import mips_defs::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_rst_val;
  logic [2:0]  state;
  logic        instr_done;
  logic [31:0] cycle_cnt;

  mc_ctrl_if bus ();

  mc_ctrl #(.IM_BASE(32'h0000_3000)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .pc_rst_val (pc_rst_val),
    .state      (state),
    .instr_done (instr_done),
    .cycle_cnt  (cycle_cnt)
  );

  always #5 clk = ~clk;

  logic [18:0] ctrlQ[$];
  logic [31:0] cntQ[$];
  string       nameQ[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] expCnt = '0;

  // Vector layout: {state, pc_wr, npc_op, ir_wr, reg_wr, reg_dst, wd_sel, ext_op, alu_src, alu_op, mem_wr, instr_done}
  function automatic logic [18:0] mk(input logic [2:0] st, input logic pw, input logic [1:0] npc,
                                     input logic iw, input logic rw, input logic [1:0] rd,
                                     input logic [1:0] wd, input logic [1:0] ext, input logic src,
                                     input logic [1:0] alu, input logic mw, input logic dn);
    return {st, pw, npc, iw, rw, rd, wd, ext, src, alu, mw, dn};
  endfunction

  task automatic applyStimulus(input string nm, input logic r, input logic [31:0] i,
                               input logic z, input logic [18:0] e);
    @(posedge clk);
    #1;
    if (reset) expCnt = '0;
    else       expCnt = expCnt + 32'd1;
    reset     = r;
    bus.instr = i;
    bus.zero  = z;
    ctrlQ.push_back(e);
    cntQ.push_back(expCnt);
    nameQ.push_back(nm);
  endtask

  task automatic checkOutput(input string nm, input logic [18:0] e, input logic [31:0] c);
    logic [18:0] act;
    act = {state, bus.pc_wr, bus.npc_op, bus.ir_wr, bus.reg_wr, bus.reg_dst, bus.wd_sel,
           bus.ext_op, bus.alu_src, bus.alu_op, bus.mem_wr, instr_done};
    vectors++;
    if (act !== e || cycle_cnt !== c) begin
      miscompares++;
      $display("[TB] FAIL %s: got ctrl=%b cnt=%0d, want ctrl=%b cnt=%0d", nm, act, cycle_cnt, e, c);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (ctrlQ.size() > 0) checkOutput(nameQ.pop_front(), ctrlQ.pop_front(), cntQ.pop_front());
    end
  end

  initial begin
    logic [18:0] rz, f, d0;
    rz = mk(3'd0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 0);
    f  = mk(3'd0, 1, 2'b00, 1, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 0);
    d0 = mk(3'd1, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 0);
    bus.instr = '0;
    bus.zero  = 1'b0;

    for (int k = 0; k < 3; k++) applyStimulus("reset_hold", 1, 32'h0, 0, rz);

    applyStimulus("lui_fetch", 0, 32'h3c01_1234, 0, f);
    applyStimulus("lui_dec",   0, 32'h3c01_1234, 0, d0);
    applyStimulus("lui_exe",   0, 32'h3c01_1234, 0, mk(3'd2, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b10, 1, 2'b10, 0, 0));
    applyStimulus("lui_wb",    0, 32'h3c01_1234, 0, mk(3'd4, 0, 2'b00, 0, 1, 2'b00, 2'b00, 2'b10, 1, 2'b10, 0, 1));

    applyStimulus("lw_fetch", 0, 32'h8c22_0004, 0, f);
    applyStimulus("lw_dec",   0, 32'h8c22_0004, 0, d0);
    applyStimulus("lw_exe",   0, 32'h8c22_0004, 0, mk(3'd2, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 0, 0));
    applyStimulus("lw_mem",   0, 32'h8c22_0004, 0, mk(3'd3, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 0, 0));
    applyStimulus("lw_wb",    0, 32'h8c22_0004, 0, mk(3'd4, 0, 2'b00, 0, 1, 2'b00, 2'b01, 2'b00, 1, 2'b00, 0, 1));

    applyStimulus("beq1_fetch", 0, 32'h1022_0003, 1, f);
    applyStimulus("beq1_dec",   0, 32'h1022_0003, 1, d0);
    applyStimulus("beq1_exe",   0, 32'h1022_0003, 1, mk(3'd2, 1, 2'b01, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b01, 0, 1));
    applyStimulus("beq0_fetch", 0, 32'h1022_0003, 0, f);
    applyStimulus("beq0_dec",   0, 32'h1022_0003, 0, d0);
    applyStimulus("beq0_exe",   0, 32'h1022_0003, 0, mk(3'd2, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b01, 0, 1));

    applyStimulus("jal_fetch", 0, 32'h0c00_0c00, 0, f);
    applyStimulus("jal_dec",   0, 32'h0c00_0c00, 0, mk(3'd1, 1, 2'b10, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 0));
    applyStimulus("jal_wb",    0, 32'h0c00_0c00, 0, mk(3'd4, 0, 2'b00, 0, 1, 2'b10, 2'b10, 2'b00, 0, 2'b00, 0, 1));
    applyStimulus("jr_fetch",  0, 32'h03e0_0008, 0, f);
    applyStimulus("jr_dec",    0, 32'h03e0_0008, 0, mk(3'd1, 1, 2'b11, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 1));
    applyStimulus("j_fetch",   0, 32'h0800_0c00, 0, f);
    applyStimulus("j_dec",     0, 32'h0800_0c00, 0, mk(3'd1, 1, 2'b10, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 1));

    applyStimulus("addu_fetch", 0, 32'h0022_1821, 0, f);
    applyStimulus("addu_dec",   0, 32'h0022_1821, 0, d0);
    applyStimulus("addu_exe",   0, 32'h0022_1821, 0, mk(3'd2, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 0));
    applyStimulus("addu_wb",    0, 32'h0022_1821, 0, mk(3'd4, 0, 2'b00, 0, 1, 2'b01, 2'b00, 2'b00, 0, 2'b00, 0, 1));
    applyStimulus("subu_fetch", 0, 32'h0022_1823, 0, f);
    applyStimulus("subu_dec",   0, 32'h0022_1823, 0, d0);
    applyStimulus("subu_exe",   0, 32'h0022_1823, 0, mk(3'd2, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b01, 0, 0));
    applyStimulus("subu_wb",    0, 32'h0022_1823, 0, mk(3'd4, 0, 2'b00, 0, 1, 2'b01, 2'b00, 2'b00, 0, 2'b01, 0, 1));
    applyStimulus("ori_fetch",  0, 32'h3421_0005, 0, f);
    applyStimulus("ori_dec",    0, 32'h3421_0005, 0, d0);
    applyStimulus("ori_exe",    0, 32'h3421_0005, 0, mk(3'd2, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b01, 1, 2'b10, 0, 0));
    applyStimulus("ori_wb",     0, 32'h3421_0005, 0, mk(3'd4, 0, 2'b00, 0, 1, 2'b00, 2'b00, 2'b01, 1, 2'b10, 0, 1));

    applyStimulus("sw_fetch", 0, 32'hac22_0008, 0, f);
    applyStimulus("sw_dec",   0, 32'hac22_0008, 0, d0);
    applyStimulus("sw_exe",   0, 32'hac22_0008, 0, mk(3'd2, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 0, 0));
    applyStimulus("sw_mem",   0, 32'hac22_0008, 0, mk(3'd3, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 1, 1));

    applyStimulus("unk_fetch",  0, 32'hfc00_0000, 0, f);
    applyStimulus("unk_dec",    0, 32'hfc00_0000, 0, mk(3'd1, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 1));
    applyStimulus("add_fetch",  0, 32'h0022_1820, 0, f);
    applyStimulus("add_dec",    0, 32'h0022_1820, 0, mk(3'd1, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 1));

    applyStimulus("swr_fetch",   0, 32'hac22_0008, 0, f);
    applyStimulus("swr_dec",     0, 32'hac22_0008, 0, d0);
    applyStimulus("swr_exe",     0, 32'hac22_0008, 0, mk(3'd2, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 0, 0));
    applyStimulus("swr_mem_rst", 1, 32'hac22_0008, 0, mk(3'd3, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 0));
    applyStimulus("post_rst_fetch", 0, 32'h3c01_1234, 0, f);
    applyStimulus("post_rst_dec",   0, 32'h3c01_1234, 0, d0);

    for (int k = 0; k < 10 && ctrlQ.size() != 0; k++) @(posedge clk);
    if (ctrlQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending vectors, want 0", ctrlQ.size());
    end

    vectors++;
    if (pc_rst_val !== 32'h0000_3000) begin
      miscompares++;
      $display("[TB] FAIL pc_rst_val: got %h, want 00003000", pc_rst_val);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
